// File: rtl/ss_salida_pkg.sv
// ----------------------------------------------------------------------------
// ss_salida_pkg
// Shared types and constants for the Booth multiplier output subsystem:
// conversion FSM states, product/BCD widths and the active-low 7-segment
// glyphs ({g,f,e,d,c,b,a}, common-anode display).
// ----------------------------------------------------------------------------
package ss_salida_pkg;

   localparam int PW         = 8;               // signed product width
   localparam int BCD_DIGITS = 3;               // |product| <= 128 -> 3 digits
   localparam int BCD_W      = 4 * BCD_DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   // Glyph table, entry n = digit n (entry 0 is the rightmost slice).
   localparam logic [9:0][6:0] SEG_GLYPH = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/ss_salida_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg
// Combinational decimal digit -> active-low 7-segment decoder.
//   digit_i : BCD digit 0-9 (codes above 9 decode to blank)
//   blank_i : force the digit dark (leading-zero suppression)
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module hex7seg
   import ss_salida_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      seg_o = SEG_BLANK;
      if (!blank_i && (digit_i <= 4'd9)) begin
         seg_o = SEG_GLYPH[digit_i];
      end
   end

endmodule

// File: rtl/ss_salida.sv
// ----------------------------------------------------------------------------
// ss_salida
// Output end of the Booth multiplier datapath. Captures the signed product on
// a one-cycle valid strobe, converts |Y| to BCD with a sequential double-dabble
// engine (one shift per clock), then shows sign/hundreds/tens/units on a
// 4-digit multiplexed common-anode display with leading-zero blanking.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   Y     : signed product, sampled when valid=1 and the engine is idle
//   valid : one-cycle request strobe (ignored while busy)
//   busy  : capture/conversion in progress
//   done  : one-cycle pulse when the digit registers take a new value
//   an    : digit enables, active-low one-hot (an[0]=units, an[3]=sign)
//   seg   : segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module ss_salida
   import ss_salida_pkg::*;
#(
   parameter int REFRESH_DIV = 16   // cycles each digit stays lit, min 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] Y,
   input  logic          valid,
   output logic          busy,
   output logic          done,
   output logic [3:0]    an,
   output logic [6:0]    seg
);

   localparam int              CW       = $clog2(PW);
   localparam int              RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]   BIT_LAST = CW'(PW - 1);

   // ---------------- conversion FSM ----------------
   state_t             state_q, state_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      mag_q, mag_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]      bit_q, bit_d;
   logic               sign_q, sign_d;
   logic [3:0]         hund_q, hund_d, tens_q, tens_d, units_q, units_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         neg_q   <= 1'b0;
         mag_q   <= '0;
         bcd_q   <= '0;
         bit_q   <= '0;
         sign_q  <= 1'b0;
         hund_q  <= '0;
         tens_q  <= '0;
         units_q <= '0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
         neg_q   <= neg_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         bit_q   <= bit_d;
         sign_q  <= sign_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         units_q <= units_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      bit_d   = bit_q;
      sign_d  = sign_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      units_d = units_q;
      done_d  = 1'b0;
      bcd_adj = bcd_q;

      unique case (state_q)
         IDLE: begin
            if (valid) begin
               neg_d   = Y[PW-1];
               // Two's-complement negate; -128 yields 8'h80 = 128 unsigned.
               mag_d   = Y[PW-1] ? (~Y + 1'b1) : Y;
               bcd_d   = '0;
               bit_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            // NOTE: blocking assignments inside always_comb let bcd_adj be
            // corrected nibble by nibble before the shift reads it.
            for (int i = 0; i < BCD_DIGITS; i++) begin
               if (bcd_adj[4*i +: 4] >= 4'd5) begin
                  bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
               end
            end
            {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            sign_d  = neg_q;
            hund_d  = bcd_q[11:8];
            tens_d  = bcd_q[7:4];
            units_d = bcd_q[3:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

   // ---------------- display scan ----------------
   logic [RW-1:0] ref_q;
   logic [1:0]    idx_q;
   logic [3:0]    digit_sel;
   logic          blank_sel;
   logic [6:0]    hex_seg;
   logic [6:0]    seg_d;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q <= '0;
         idx_q <= '0;
      end else if (ref_q == REF_LAST) begin
         ref_q <= '0;
         idx_q <= idx_q + 1'b1;   // 3 -> 0 wraps naturally
      end else begin
         ref_q <= ref_q + 1'b1;
      end
   end

   always_comb begin
      digit_sel = units_q;
      blank_sel = 1'b0;
      unique case (idx_q)
         2'd0: begin digit_sel = units_q; blank_sel = 1'b0;                          end
         2'd1: begin digit_sel = tens_q;  blank_sel = (hund_q == 4'd0) && (tens_q == 4'd0); end
         2'd2: begin digit_sel = hund_q;  blank_sel = (hund_q == 4'd0);               end
         2'd3: begin digit_sel = 4'd0;    blank_sel = 1'b1;                           end
         default: ;
      endcase
   end

   hex7seg u_hex7seg (
      .digit_i (digit_sel),
      .blank_i (blank_sel),
      .seg_o   (hex_seg)
   );

   // Sign slot bypasses the decoder: it only ever shows minus or nothing.
   assign seg_d = (idx_q == 2'd3) ? (sign_q ? SEG_MINUS : SEG_BLANK) : hex_seg;

   // Registering an/seg together keeps them switching on the same edge, so no
   // digit ever sees its neighbour's segments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= 4'b1110;
         seg_q <= SEG_GLYPH[0];
      end else begin
         an_q  <= ~(4'b0001 << idx_q);
         seg_q <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
